vga_timing_detect: RTL

//  Receive-side counterpart of the pixel timing generator: watches an incoming hs/vs/de stream
//  on the pixel clock, measures H/V total and active sizes, regenerates pixel coordinates,
//  and flags lock once timing is stable. Sits after a video input or generator loopback,

---
 rtl/vga_timing_detect_if.sv | 30 +++
 rtl/vga_timing_detect.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_detect_if.sv
// rtl/vga_timing_detect_if.sv - sync/de input stream and measurement outputs of vga_timing_detect
interface vga_timing_detect_if #(
    parameter int CNT_W = 12
);
    logic             hs_in;
    logic             vs_in;
    logic             de_in;
    logic [CNT_W-1:0] h_total;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_total;
    logic [CNT_W-1:0] v_active;
    logic [9:0]       pos_x;
    logic [9:0]       pos_y;
    logic             pos_valid;
    logic             frame_start;
    logic             locked;
    logic             err;

    modport master (
        output hs_in, vs_in, de_in,
        input  h_total, h_active, v_total, v_active,
        input  pos_x, pos_y, pos_valid, frame_start, locked, err
    );

    modport slave (
        input  hs_in, vs_in, de_in,
        output h_total, h_active, v_total, v_active,
        output pos_x, pos_y, pos_valid, frame_start, locked, err
    );
endinterface

// File: rtl/vga_timing_detect.sv
// rtl/vga_timing_detect.sv - measures incoming video timing, regenerates coordinates, flags lock
module vga_timing_detect #(
    parameter logic HS_POL      = 1'b1,
    parameter logic VS_POL      = 1'b1,
    parameter int   LOCK_FRAMES = 2,
    parameter int   CNT_W       = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_timing_detect_if.slave vid
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [9:0]       POS_MAX = 10'd1023;
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_FRAMES);

    // S_IDLE is the first-frame state: the next vs edge only starts a measurement
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             hs_a_q, vs_a_q, de_a_q, hs_p_q, vs_p_q;
    logic             hs_rise, vs_rise;
    logic [CNT_W-1:0] hclk_q, hclk_d;
    logic [CNT_W-1:0] decnt_q, decnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] vact_q, vact_d;
    logic [CNT_W-1:0] last_htot_q, last_htot_d;
    logic [CNT_W-1:0] last_hact_q, last_hact_d;
    logic [CNT_W-1:0] line_len, line_de, new_vtot, new_vact;
    logic             closed_act;
    logic [CNT_W-1:0] h_total_q, h_active_q, v_total_q, v_active_q;
    logic             snap_en, tuple_eq;
    logic [3:0]       match_q, match_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             frame_start_q;
    logic             h_to_q, h_to_d, v_to_q, v_to_d;
    logic             h_hit, v_hit, timeout;
    logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic             pos_valid_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == CNT_MAX) ? x : x + CNT_W'(1);
    endfunction

    function automatic logic [9:0] sat10(input logic [CNT_W-1:0] x);
        return (x > CNT_W'(POS_MAX)) ? POS_MAX : x[9:0];
    endfunction

    assign hs_rise = hs_a_q & ~hs_p_q;
    assign vs_rise = vs_a_q & ~vs_p_q;

    // Line/frame measurement. The hs edge coincident with a vs edge opens line 0 of the new frame,
    // while the line it closes still belongs to the frame being snapshotted.
    always_comb begin
        line_len    = sat_inc(hclk_q);
        line_de     = de_a_q ? sat_inc(decnt_q) : decnt_q;
        closed_act  = hs_rise && (line_de != '0);
        hclk_d      = hs_rise ? '0 : sat_inc(hclk_q);
        decnt_d     = hs_rise ? '0 : line_de;
        last_htot_d = hs_rise ? line_len : last_htot_q;
        last_hact_d = closed_act ? line_de : last_hact_q;
        new_vtot    = vcnt_q;
        new_vact    = closed_act ? sat_inc(vact_q) : vact_q;
        if (vs_rise) begin
            vcnt_d = hs_rise ? CNT_W'(1) : '0;
            vact_d = '0;
        end else begin
            vcnt_d = hs_rise ? sat_inc(vcnt_q) : vcnt_q;
            vact_d = new_vact;
        end
        pos_x_d = sat10(hs_rise ? '0 : decnt_q);
        pos_y_d = sat10(vact_d);
    end

    // A saturated counter reports once; it re-arms only when its own edge restarts it
    always_comb begin
        h_hit  = (hclk_q == CNT_MAX) && !h_to_q && !hs_rise;
        v_hit  = (vcnt_q == CNT_MAX) && !v_to_q && !vs_rise;
        h_to_d = hs_rise ? 1'b0 : (h_to_q | (hclk_q == CNT_MAX));
        v_to_d = vs_rise ? 1'b0 : (v_to_q | (vcnt_q == CNT_MAX));
        timeout = h_hit | v_hit;
    end

    assign tuple_eq = ({last_htot_d, last_hact_d, new_vtot, new_vact} ==
                       {h_total_q, h_active_q, v_total_q, v_active_q});

    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        snap_en  = 1'b0;
        if (timeout) begin
            state_d  = S_IDLE;
            match_d  = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
        end else if (vs_rise) begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FIRST;
                end
                S_FIRST: begin
                    snap_en = 1'b1;
                    state_d = S_TRACK;
                end
                S_TRACK: begin
                    snap_en = 1'b1;
                    if (tuple_eq) begin
                        if (match_q < LOCK_N) begin
                            match_d = match_q + 4'd1;
                        end
                        locked_d = (match_d == LOCK_N);
                    end else begin
                        match_d  = '0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            hs_a_q        <= 1'b0;
            vs_a_q        <= 1'b0;
            de_a_q        <= 1'b0;
            hs_p_q        <= 1'b0;
            vs_p_q        <= 1'b0;
            hclk_q        <= '0;
            decnt_q       <= '0;
            vcnt_q        <= '0;
            vact_q        <= '0;
            last_htot_q   <= '0;
            last_hact_q   <= '0;
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            match_q       <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            frame_start_q <= 1'b0;
            h_to_q        <= 1'b0;
            v_to_q        <= 1'b0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            pos_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_a_q        <= (vid.hs_in == HS_POL);
            vs_a_q        <= (vid.vs_in == VS_POL);
            de_a_q        <= vid.de_in;
            hs_p_q        <= hs_a_q;
            vs_p_q        <= vs_a_q;
            hclk_q        <= hclk_d;
            decnt_q       <= decnt_d;
            vcnt_q        <= vcnt_d;
            vact_q        <= vact_d;
            last_htot_q   <= last_htot_d;
            last_hact_q   <= last_hact_d;
            if (snap_en) begin
                h_total_q  <= last_htot_d;
                h_active_q <= last_hact_d;
                v_total_q  <= new_vtot;
                v_active_q <= new_vact;
            end
            match_q       <= match_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
            frame_start_q <= vs_rise;
            h_to_q        <= h_to_d;
            v_to_q        <= v_to_d;
            pos_valid_q   <= de_a_q;
            if (de_a_q) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
            end
        end
    end

    assign vid.h_total     = h_total_q;
    assign vid.h_active    = h_active_q;
    assign vid.v_total     = v_total_q;
    assign vid.v_active    = v_active_q;
    assign vid.pos_x       = pos_x_q;
    assign vid.pos_y       = pos_y_q;
    assign vid.pos_valid   = pos_valid_q;
    assign vid.frame_start = frame_start_q;
    assign vid.locked      = locked_q;
    assign vid.err         = err_q;
endmodule
